// File: rtl/mem_stage_if.sv
// EX/MEM/WB/ID connection bundle for the memory-access stage.
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 145,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_ID_WD = 104
);
    logic [5:0]              stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic                    data_ok;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;
    logic                    stallreq_mem;

    // Pipeline / stall-controller side.
    modport master (
        output stall, ex_to_mem_bus, data_sram_rdata, data_ok,
        input  mem_to_wb_bus, mem_to_id_bus, stallreq_mem
    );

    // Memory stage side.
    modport slave (
        input  stall, ex_to_mem_bus, data_sram_rdata, data_ok,
        output mem_to_wb_bus, mem_to_id_bus, stallreq_mem
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX bus, waits for SRAM load data,
// aligns/extends it, and keeps returned data across downstream stalls.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 145,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_ID_WD = 104
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave io
);
    logic [EX_TO_MEM_WD-1:0] bus_r;
    logic                    buf_valid;
    logic [31:0]             rdata_buf;

    logic        hi_we, lo_we;
    logic [31:0] hi_ex, lo_ex, mem_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [2:0]  ld_type;

    logic        bus_load, bus_bubble, buf_clear;
    logic        pending, occupied;
    logic [31:0] raw, aligned, rf_wdata;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [MEM_TO_WB_WD-1:0] wb_bus;
    logic [MEM_TO_ID_WD-1:0] id_bus;

    assign {hi_we, lo_we, hi_ex, lo_ex, mem_pc, data_ram_en, data_ram_wen,
            sel_rf_res, rf_we, rf_waddr, ex_result, ld_type} = bus_r;

    assign bus_load   = ~io.stall[4];
    assign bus_bubble = io.stall[4] & ~io.stall[5];
    assign buf_clear  = bus_load | bus_bubble;

    assign pending = data_ram_en & ~buf_valid;
    assign raw     = buf_valid ? rdata_buf : io.data_sram_rdata;

    // EX->MEM pipeline register: reset, bubble, advance, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_r <= '0;
        end else if (bus_bubble) begin
            bus_r <= '0;
        end else if (bus_load) begin
            bus_r <= io.ex_to_mem_bus;
        end
    end

    // Capture returned SRAM data so a downstream stall cannot lose it;
    // any change of the instruction in MEM discards the buffer.
    always_ff @(posedge clk) begin
        if (rst || buf_clear) begin
            buf_valid <= 1'b0;
            rdata_buf <= '0;
        end else if (io.data_ok && pending) begin
            buf_valid <= 1'b1;
            rdata_buf <= io.data_sram_rdata;
        end
    end

    // Byte/halfword selection and sign/zero extension of the load data.
    always_comb begin
        sel_byte = raw[7:0];
        sel_half = ex_result[1] ? raw[31:16] : raw[15:0];
        aligned  = raw;
        case (ex_result[1:0])
            2'd0: sel_byte = raw[7:0];
            2'd1: sel_byte = raw[15:8];
            2'd2: sel_byte = raw[23:16];
            default: sel_byte = raw[31:24];
        endcase
        case (ld_type)
            3'd1: aligned = {{24{sel_byte[7]}}, sel_byte};
            3'd2: aligned = {24'd0, sel_byte};
            3'd3: aligned = {{16{sel_half[15]}}, sel_half};
            3'd4: aligned = {16'd0, sel_half};
            default: aligned = raw;
        endcase
    end

    // Result selection and output bus assembly; an empty slot drives zeros.
    always_comb begin
        occupied = |bus_r;
        rf_wdata = sel_rf_res ? aligned : ex_result;
        wb_bus   = '0;
        id_bus   = '0;
        if (occupied) begin
            wb_bus = {hi_we, lo_we, hi_ex, lo_ex, mem_pc, rf_we, rf_waddr, rf_wdata};
            id_bus = {hi_we, lo_we, hi_ex, lo_ex, rf_we, rf_waddr, rf_wdata};
        end
    end

    assign io.mem_to_wb_bus = wb_bus;
    assign io.mem_to_id_bus = id_bus;
    assign io.stallreq_mem  = pending & ~io.data_ok;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: extension table, directed multi-cycle
// sequences, and randomized traffic against a field-level reference model.
module tb_mem_stage;
    typedef struct {
        logic        hi_we, lo_we;
        logic [31:0] hi_ex, lo_ex, pc;
        logic        en;
        logic [3:0]  wen;
        logic        sel, we;
        logic [4:0]  waddr;
        logic [31:0] res;
        logic [2:0]  ld;
    } instr_t;

    typedef struct {
        logic [2:0]  ld;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ext_vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if #(.EX_TO_MEM_WD(145), .MEM_TO_WB_WD(136), .MEM_TO_ID_WD(104)) io ();

    mem_stage #(.EX_TO_MEM_WD(145), .MEM_TO_WB_WD(136), .MEM_TO_ID_WD(104)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: the instruction occupying MEM and the saved load data.
    instr_t      m_cur;
    logic        m_has;
    logic [31:0] m_buf;
    instr_t      zero_i;

    function automatic logic [144:0] pack(input instr_t i);
        return {i.hi_we, i.lo_we, i.hi_ex, i.lo_ex, i.pc, i.en, i.wen,
                i.sel, i.we, i.waddr, i.res, i.ld};
    endfunction

    function automatic instr_t unpack(input logic [144:0] b);
        instr_t i;
        {i.hi_we, i.lo_we, i.hi_ex, i.lo_ex, i.pc, i.en, i.wen,
         i.sel, i.we, i.waddr, i.res, i.ld} = b;
        return i;
    endfunction

    function automatic logic [31:0] ref_align(input logic [2:0] ld, input logic [31:0] addr,
                                              input logic [31:0] raw);
        longint unsigned b, h;
        b = (longint'(raw) >> (8 * (addr % 4))) % 256;
        h = (longint'(raw) >> (16 * ((addr / 2) % 2))) % 65536;
        case (ld)
            3'd1: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            3'd2: return 32'(b);
            3'd3: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            3'd4: return 32'(h);
            default: return raw;
        endcase
    endfunction

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare DUT against the model for the current cycle, then advance one clock.
    task automatic step(input string name);
        logic [31:0]  raw, wd;
        logic         exp_stall;
        logic [135:0] exp_wb;
        logic [103:0] exp_id;
        logic         empty;
        instr_t       nxt;
        #1;
        empty     = (pack(m_cur) == '0);
        raw       = m_has ? m_buf : io.data_sram_rdata;
        wd        = m_cur.sel ? ref_align(m_cur.ld, m_cur.res, raw) : m_cur.res;
        exp_stall = m_cur.en && !m_has && !io.data_ok;
        exp_wb    = empty ? '0 : {m_cur.hi_we, m_cur.lo_we, m_cur.hi_ex, m_cur.lo_ex,
                                  m_cur.pc, m_cur.we, m_cur.waddr, wd};
        exp_id    = empty ? '0 : {m_cur.hi_we, m_cur.lo_we, m_cur.hi_ex, m_cur.lo_ex,
                                  m_cur.we, m_cur.waddr, wd};
        chk({name, " stallreq"}, 144'(io.stallreq_mem), 144'(exp_stall));
        chk({name, " wb_bus"},   144'(io.mem_to_wb_bus), 144'(exp_wb));
        chk({name, " id_bus"},   144'(io.mem_to_id_bus), 144'(exp_id));
        nxt = unpack(io.ex_to_mem_bus);
        if (rst || (io.stall[4] && !io.stall[5])) begin
            m_cur = zero_i;
            m_has = 1'b0;
        end else if (!io.stall[4]) begin
            m_cur = nxt;
            m_has = 1'b0;
        end else if (m_cur.en && !m_has && io.data_ok) begin
            m_has = 1'b1;
            m_buf = io.data_sram_rdata;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk_load(input logic [2:0] ld, input logic [31:0] addr,
                                       input logic [4:0] wa);
        instr_t i = zero_i;
        i.en = 1'b1; i.sel = 1'b1; i.we = 1'b1; i.waddr = wa; i.res = addr; i.ld = ld;
        i.pc = 32'hBFC0_0100;
        return i;
    endfunction

    task automatic drive(input instr_t i, input logic [5:0] st, input logic ok,
                         input logic [31:0] rd);
        io.ex_to_mem_bus   = pack(i);
        io.stall           = st;
        io.data_ok         = ok;
        io.data_sram_rdata = rd;
    endtask

    ext_vec_t vecs[12];
    instr_t   ti, alu;
    int unsigned hi_cnt;

    initial begin
        zero_i = unpack('0);
        m_cur  = zero_i;
        m_has  = 1'b0;
        m_buf  = '0;
        rst    = 1'b1;
        drive(zero_i, 6'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;

        // Reset state
        step("reset");
        rst = 1'b0;
        chk("reset wb zero", 144'(io.mem_to_wb_bus), 144'd0);

        // lw hit and extension table
        vecs[0]  = '{3'd0, 32'h0000_1000, 32'h8765_4321, 32'h8765_4321};
        vecs[1]  = '{3'd1, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80};
        vecs[2]  = '{3'd2, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080};
        vecs[3]  = '{3'd3, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_7F01};
        vecs[4]  = '{3'd4, 32'h0000_1002, 32'h80FF_7F01, 32'h0000_80FF};
        vecs[5]  = '{3'd1, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_0001};
        vecs[6]  = '{3'd1, 32'h0000_1001, 32'h80FF_7F01, 32'h0000_007F};
        vecs[7]  = '{3'd1, 32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_FFFF};
        vecs[8]  = '{3'd3, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_80FF};
        vecs[9]  = '{3'd4, 32'h0000_1001, 32'h80FF_7F01, 32'h0000_7F01};
        vecs[10] = '{3'd5, 32'h0000_1002, 32'h80FF_7F01, 32'h80FF_7F01};
        vecs[11] = '{3'd7, 32'h0000_1001, 32'h80FF_7F01, 32'h80FF_7F01};
        for (int k = 0; k < 12; k++) begin
            drive(mk_load(vecs[k].ld, vecs[k].addr, 5'd5), 6'd0, 1'b0, 32'd0);
            step("ext enter");
            drive(zero_i, 6'd0, 1'b1, vecs[k].rdata);
            #1;
            chk($sformatf("ext[%0d] rf_wdata", k), 144'(io.mem_to_wb_bus[31:0]), 144'(vecs[k].exp));
            chk($sformatf("ext[%0d] rf_waddr", k), 144'(io.mem_to_wb_bus[36:32]), 144'd5);
            chk($sformatf("ext[%0d] stallreq", k), 144'(io.stallreq_mem), 144'd0);
            step("ext hit");
        end

        // Miss: data_ok three cycles after entry, stall fed back from stallreq_mem
        alu = zero_i;
        alu.we = 1'b1; alu.waddr = 5'd9; alu.res = 32'h0000_0ABC; alu.pc = 32'hBFC0_0200;
        ti = mk_load(3'd0, 32'h0000_2000, 5'd7);
        drive(ti, 6'd0, 1'b0, 32'd0);
        step("miss enter");
        hi_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            io.data_ok         = (k == 3);
            io.data_sram_rdata = (k == 3) ? 32'hCAFE_F00D : $urandom;
            if (k == 3) io.ex_to_mem_bus = pack(alu);
            #1;
            io.stall = io.stallreq_mem ? 6'h3F : 6'h00;
            if (io.stallreq_mem) hi_cnt++;
            if (k == 3) chk("miss rf_wdata", 144'(io.mem_to_wb_bus[31:0]), 144'(32'hCAFE_F00D));
            step("miss");
        end
        chk("miss stall cycles", 144'(hi_cnt), 144'd3);
        drive(zero_i, 6'd0, 1'b0, 32'd0);
        chk("miss next advances", 144'(io.mem_to_wb_bus[36:32]), 144'd9);
        step("after miss");

        // Held data under a later-stage stall
        drive(mk_load(3'd0, 32'h0000_3000, 5'd3), 6'd0, 1'b0, 32'd0);
        step("held enter");
        drive(zero_i, 6'h30, 1'b1, 32'hDEAD_BEEF);
        step("held data_ok");
        for (int k = 0; k < 2; k++) begin
            drive(zero_i, 6'h30, 1'b0, 32'd0);
            #1;
            chk($sformatf("held[%0d] rf_wdata", k), 144'(io.mem_to_wb_bus[31:0]), 144'(32'hDEAD_BEEF));
            chk($sformatf("held[%0d] stallreq", k), 144'(io.stallreq_mem), 144'd0);
            step("held");
        end

        // HI/LO passthrough, then bubble
        ti = zero_i;
        ti.hi_we = 1'b1; ti.hi_ex = 32'h0000_1234; ti.pc = 32'hBFC0_0300;
        drive(ti, 6'd0, 1'b0, 32'd0);
        step("hilo enter");
        chk("hilo wb hi_we", 144'(io.mem_to_wb_bus[135]), 144'd1);
        chk("hilo wb hi_ex", 144'(io.mem_to_wb_bus[133:102]), 144'(32'h1234));
        chk("hilo id hi_we", 144'(io.mem_to_id_bus[103]), 144'd1);
        chk("hilo id hi_ex", 144'(io.mem_to_id_bus[101:70]), 144'(32'h1234));
        drive(ti, 6'b010000, 1'b0, 32'd0);
        step("bubble");
        chk("bubble wb zero", 144'(io.mem_to_wb_bus), 144'd0);
        chk("bubble id zero", 144'(io.mem_to_id_bus), 144'd0);

        // Reset in the middle of a miss, then a late data_ok
        drive(mk_load(3'd1, 32'h0000_4001, 5'd11), 6'd0, 1'b0, 32'd0);
        step("rstmiss enter");
        drive(zero_i, 6'h3F, 1'b0, 32'd0);
        rst = 1'b1;
        step("rstmiss rst");
        rst = 1'b0;
        drive(zero_i, 6'h30, 1'b1, 32'h1357_9BDF);
        #1;
        chk("rstmiss wb zero", 144'(io.mem_to_wb_bus), 144'd0);
        chk("rstmiss id zero", 144'(io.mem_to_id_bus), 144'd0);
        chk("rstmiss stallreq", 144'(io.stallreq_mem), 144'd0);
        step("rstmiss late ok");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            ti = unpack({$urandom, $urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 2) == 0) ti = zero_i;
            rst = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0: io.stall = 6'h3F;
                1: io.stall = 6'(1 << 4);
                2: io.stall = 6'h30;
                default: io.stall = '0;
            endcase
            if ($urandom_range(0, 1) == 0) io.stall = '0;
            io.ex_to_mem_bus   = pack(ti);
            io.data_ok         = ($urandom_range(0, 2) == 0);
            io.data_sram_rdata = $urandom;
            step("random");
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
